// File: rtl/nrisc_ula_mc.sv
// nrisc_ula_mc - multi-cycle ALU for the NRISC core.
//
// Single-cycle ops (add/sub/logic/shift/rotate) are registered at the edge
// that samples ULA_start, and ULA_done pulses in the following cycle.
// MUL/DIV run iteratively for TAM edges (shift-add / restoring divide).
// A full-width product or the remainder is returned on ULA_OUT_HI.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   ULA_A/B      operands (shift/rotate amount = ULA_B[SHW-1:0])
//   ULA_ctrl     operation select, sampled with ULA_start while idle
//   ULA_start    request
//   ULA_OUT      result / low product / quotient
//   ULA_OUT_HI   high product / remainder (0 for single-cycle ops)
//   ULA_flags    {minus, zero, carry, overflow}
//   ULA_busy     multi-cycle op in progress
//   ULA_done     one-cycle pulse when OUT/HI/flags are updated
//
// Build option: define ULA_SIGNED_MULDIV_EN to make 0x12/0x13 signed
// (MULS/DIVS). Without it they alias MULU/DIVU.
module nrisc_ula_mc #(
    parameter int unsigned TAM = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [TAM-1:0] ULA_A,
    input  logic [TAM-1:0] ULA_B,
    input  logic [4:0]     ULA_ctrl,
    input  logic           ULA_start,
    output logic [TAM-1:0] ULA_OUT,
    output logic [TAM-1:0] ULA_OUT_HI,
    output logic [3:0]     ULA_flags,
    output logic           ULA_busy,
    output logic           ULA_done
);
    localparam int unsigned     SHW  = $clog2(TAM);
    localparam logic [SHW-1:0]  LAST = SHW'(TAM - 1);

    typedef enum logic {IDLE, RUN} state_t;

    typedef enum logic [4:0] {
        OP_ADD  = 5'h00, OP_SUB  = 5'h01, OP_AND  = 5'h02, OP_NAND = 5'h03,
        OP_OR   = 5'h04, OP_XOR  = 5'h05, OP_SHR  = 5'h06, OP_SAR  = 5'h07,
        OP_SHL  = 5'h08, OP_ROTL = 5'h09, OP_ROTR = 5'h0A, OP_NOT  = 5'h0B
    } op_t;

    state_t           state, state_nx;
    logic [SHW-1:0]   cnt, cnt_nx;
    logic [TAM-1:0]   acc, acc_nx;      // partial product high / partial remainder
    logic [TAM-1:0]   lo, lo_nx;        // multiplier / dividend-then-quotient
    logic [TAM-1:0]   bop, bop_nx;      // multiplicand / divisor
    logic [TAM-1:0]   a_orig, a_orig_nx;
    logic             is_mul, is_mul_nx;
    logic             divzero, divzero_nx;
`ifdef ULA_SIGNED_MULDIV_EN
    logic             sgn, sgn_nx;
    logic             neg_q, neg_q_nx;  // negate product / quotient
    logic             neg_r, neg_r_nx;  // negate remainder
    logic             div_ovf, div_ovf_nx;
    logic             a_neg, b_neg;
`endif

    logic [TAM-1:0]   out_nx, hi_nx;
    logic [3:0]       flags_nx;
    logic             done_nx, load, res_c, res_v;

    // ---------------- single-cycle datapath ----------------
    logic [SHW-1:0]   sh;
    logic [TAM:0]     sum_ext, dif_ext, shl_ext, shr_ext, sar_ext;
    logic [TAM-1:0]   sc_res;
    logic             sc_c, sc_v;

    assign sh = ULA_B[SHW-1:0];

    // Shifts are done one bit wider so the last bit shifted out lands in
    // the extra bit; an amount of 0 leaves that bit at 0.
    always_comb begin
        sum_ext = {1'b0, ULA_A} + {1'b0, ULA_B};
        dif_ext = {1'b0, ULA_A} - {1'b0, ULA_B};
        shl_ext = {1'b0, ULA_A} << sh;
        shr_ext = {ULA_A, 1'b0} >> sh;
        sar_ext = $signed({ULA_A, 1'b0}) >>> sh;
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        case (ULA_ctrl)
            OP_ADD: begin
                sc_res = sum_ext[TAM-1:0];
                sc_c   = sum_ext[TAM];
                sc_v   = (ULA_A[TAM-1] == ULA_B[TAM-1]) && (sum_ext[TAM-1] != ULA_A[TAM-1]);
            end
            OP_SUB: begin
                sc_res = dif_ext[TAM-1:0];
                sc_c   = dif_ext[TAM];
                sc_v   = (ULA_A[TAM-1] != ULA_B[TAM-1]) && (dif_ext[TAM-1] != ULA_A[TAM-1]);
            end
            OP_AND:  sc_res = ULA_A & ULA_B;
            OP_NAND: sc_res = ~(ULA_A & ULA_B);
            OP_OR:   sc_res = ULA_A | ULA_B;
            OP_XOR:  sc_res = ULA_A ^ ULA_B;
            OP_NOT:  sc_res = ~ULA_A;
            OP_SHR: begin
                sc_res = shr_ext[TAM:1];
                sc_c   = shr_ext[0];
            end
            OP_SAR: begin
                sc_res = sar_ext[TAM:1];
                sc_c   = sar_ext[0];
            end
            OP_SHL: begin
                sc_res = shl_ext[TAM-1:0];
                sc_c   = shl_ext[TAM];
            end
            OP_ROTL: begin
                // shifting by TAM yields 0, so amount 0 degenerates cleanly
                sc_res = (ULA_A << sh) | (ULA_A >> (TAM - sh));
                sc_c   = (sh != '0) && sc_res[0];
            end
            OP_ROTR: begin
                sc_res = (ULA_A >> sh) | (ULA_A << (TAM - sh));
                sc_c   = (sh != '0) && sc_res[TAM-1];
            end
            default: ;
        endcase
    end

    // ---------------- iterative datapath ----------------
    logic [TAM:0]     mul_sum, div_trial, div_sub;
    logic             div_ge;
    logic [TAM-1:0]   it_acc, it_lo;

    always_comb begin
        mul_sum   = {1'b0, acc} + ({1'b0, bop} & {(TAM+1){lo[0]}});
        div_trial = {acc, lo[TAM-1]};
        div_sub   = div_trial - {1'b0, bop};
        // acc < bop holds for a nonzero divisor, so the sign of the trial
        // subtraction decides; a zero divisor always "fits".
        div_ge    = (bop == '0) || !div_sub[TAM];
        if (is_mul) begin
            it_acc = mul_sum[TAM:1];
            it_lo  = {mul_sum[0], lo[TAM-1:1]};
        end else begin
            it_acc = div_ge ? div_sub[TAM-1:0] : div_trial[TAM-1:0];
            it_lo  = {lo[TAM-2:0], div_ge};
        end
    end

    // ---------------- next-state / output logic ----------------
    logic [2*TAM-1:0] prod;
    logic [TAM-1:0]   quo, rem;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        acc_nx     = acc;
        lo_nx      = lo;
        bop_nx     = bop;
        a_orig_nx  = a_orig;
        is_mul_nx  = is_mul;
        divzero_nx = divzero;
`ifdef ULA_SIGNED_MULDIV_EN
        sgn_nx     = sgn;
        neg_q_nx   = neg_q;
        neg_r_nx   = neg_r;
        div_ovf_nx = div_ovf;
        a_neg      = ULA_ctrl[1] & ULA_A[TAM-1];
        b_neg      = ULA_ctrl[1] & ULA_B[TAM-1];
`endif
        out_nx     = ULA_OUT;
        hi_nx      = ULA_OUT_HI;
        done_nx    = 1'b0;
        load       = 1'b0;
        res_c      = 1'b0;
        res_v      = 1'b0;
        prod       = {it_acc, it_lo};
        quo        = it_lo;
        rem        = it_acc;

        case (state)
            IDLE: begin
                if (ULA_start) begin
                    if (ULA_ctrl[4:2] == 3'b100) begin
                        state_nx   = RUN;
                        cnt_nx     = '0;
                        acc_nx     = '0;
                        is_mul_nx  = ~ULA_ctrl[0];
                        divzero_nx = (ULA_B == '0);
                        a_orig_nx  = ULA_A;
`ifdef ULA_SIGNED_MULDIV_EN
                        // iterate on magnitudes, fix signs on the last edge
                        sgn_nx     = ULA_ctrl[1];
                        lo_nx      = a_neg ? ('0 - ULA_A) : ULA_A;
                        bop_nx     = b_neg ? ('0 - ULA_B) : ULA_B;
                        neg_q_nx   = a_neg ^ b_neg;
                        neg_r_nx   = a_neg;
                        div_ovf_nx = ULA_ctrl[1] & ULA_ctrl[0] &
                                     (ULA_A == {1'b1, {(TAM-1){1'b0}}}) & (ULA_B == '1);
`else
                        lo_nx      = ULA_A;
                        bop_nx     = ULA_B;
`endif
                    end else begin
                        load    = 1'b1;
                        done_nx = 1'b1;
                        out_nx  = sc_res;
                        hi_nx   = '0;
                        res_c   = sc_c;
                        res_v   = sc_v;
                    end
                end
            end
            RUN: begin
                acc_nx = it_acc;
                lo_nx  = it_lo;
                cnt_nx = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    done_nx  = 1'b1;
                    load     = 1'b1;
                    if (is_mul) begin
`ifdef ULA_SIGNED_MULDIV_EN
                        if (neg_q) prod = '0 - prod;
`endif
                        out_nx = prod[TAM-1:0];
                        hi_nx  = prod[2*TAM-1:TAM];
`ifdef ULA_SIGNED_MULDIV_EN
                        res_v  = sgn ? (prod[2*TAM-1:TAM] != {TAM{prod[TAM-1]}})
                                     : (prod[2*TAM-1:TAM] != '0);
`else
                        res_v  = (prod[2*TAM-1:TAM] != '0);
`endif
                    end else if (divzero) begin
                        out_nx = '1;
                        hi_nx  = a_orig;
                        res_c  = 1'b1;
                    end else begin
`ifdef ULA_SIGNED_MULDIV_EN
                        if (neg_q) quo = '0 - quo;
                        if (neg_r) rem = '0 - rem;
                        res_v  = div_ovf;
`endif
                        out_nx = quo;
                        hi_nx  = rem;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        flags_nx = load ? {out_nx[TAM-1], (out_nx == '0) && (hi_nx == '0), res_c, res_v}
                        : ULA_flags;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            lo         <= '0;
            bop        <= '0;
            a_orig     <= '0;
            is_mul     <= 1'b0;
            divzero    <= 1'b0;
`ifdef ULA_SIGNED_MULDIV_EN
            sgn        <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_ovf    <= 1'b0;
`endif
            ULA_OUT    <= '0;
            ULA_OUT_HI <= '0;
            ULA_flags  <= '0;
            ULA_done   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            acc        <= acc_nx;
            lo         <= lo_nx;
            bop        <= bop_nx;
            a_orig     <= a_orig_nx;
            is_mul     <= is_mul_nx;
            divzero    <= divzero_nx;
`ifdef ULA_SIGNED_MULDIV_EN
            sgn        <= sgn_nx;
            neg_q      <= neg_q_nx;
            neg_r      <= neg_r_nx;
            div_ovf    <= div_ovf_nx;
`endif
            ULA_OUT    <= out_nx;
            ULA_OUT_HI <= hi_nx;
            ULA_flags  <= flags_nx;
            ULA_done   <= done_nx;
        end
    end

    assign ULA_busy = (state == RUN);

endmodule

// File: tb/tb_nrisc_ula_mc.sv
// tb_nrisc_ula_mc - directed self-checking bench for nrisc_ula_mc (TAM=32).
module tb_nrisc_ula_mc;
    localparam int unsigned TAM = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [TAM-1:0] ULA_A, ULA_B;
    logic [4:0]     ULA_ctrl;
    logic           ULA_start;
    logic [TAM-1:0] ULA_OUT, ULA_OUT_HI;
    logic [3:0]     ULA_flags;
    logic           ULA_busy, ULA_done;

    int n_checks = 0;
    int n_fail   = 0;

    nrisc_ula_mc #(.TAM(TAM)) dut (
        .clk        (clk),
        .rst        (rst),
        .ULA_A      (ULA_A),
        .ULA_B      (ULA_B),
        .ULA_ctrl   (ULA_ctrl),
        .ULA_start  (ULA_start),
        .ULA_OUT    (ULA_OUT),
        .ULA_OUT_HI (ULA_OUT_HI),
        .ULA_flags  (ULA_flags),
        .ULA_busy   (ULA_busy),
        .ULA_done   (ULA_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // single-cycle op: done must be up right after the sampling edge
    task automatic sc_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eo, input logic [3:0] ef);
        ULA_ctrl  = op;
        ULA_A     = a;
        ULA_B     = b;
        ULA_start = 1'b1;
        tick();
        ULA_start = 1'b0;
        chk($sformatf("%s.done", tag), ULA_done, 1);
        chk($sformatf("%s.busy", tag), ULA_busy, 0);
        chk($sformatf("%s.out", tag), ULA_OUT, eo);
        chk($sformatf("%s.hi", tag), ULA_OUT_HI, 0);
        chk($sformatf("%s.flags", tag), ULA_flags, ef);
        tick();
        chk($sformatf("%s.done_pulse", tag), ULA_done, 0);
    endtask

    // multi-cycle op; inj >= 0 pulses a conflicting start at that cycle
    task automatic mc_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eo, input logic [31:0] eh,
                         input logic [3:0] ef, input int inj);
        int cyc;
        ULA_ctrl  = op;
        ULA_A     = a;
        ULA_B     = b;
        ULA_start = 1'b1;
        tick();
        ULA_start = 1'b0;
        chk($sformatf("%s.busy_start", tag), ULA_busy, 1);
        chk($sformatf("%s.done_start", tag), ULA_done, 0);
        cyc = 0;
        while (!ULA_done && cyc < 100) begin
            if (cyc == inj) begin
                ULA_ctrl  = 5'h00;
                ULA_A     = 32'd3;
                ULA_B     = 32'd4;
                ULA_start = 1'b1;
            end
            tick();
            if (cyc == inj) begin
                ULA_start = 1'b0;
                chk($sformatf("%s.busy_inj", tag), ULA_busy, 1);
            end
            cyc++;
        end
        chk($sformatf("%s.latency", tag), cyc, TAM);
        chk($sformatf("%s.busy_end", tag), ULA_busy, 0);
        chk($sformatf("%s.out", tag), ULA_OUT, eo);
        chk($sformatf("%s.hi", tag), ULA_OUT_HI, eh);
        chk($sformatf("%s.flags", tag), ULA_flags, ef);
        tick();
        tick();
        chk($sformatf("%s.done_pulse", tag), ULA_done, 0);
        chk($sformatf("%s.hold", tag), ULA_OUT, eo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        rst       = 1'b1;
        ULA_A     = '0;
        ULA_B     = '0;
        ULA_ctrl  = '0;
        ULA_start = 1'b0;
        tick();
        tick();
        chk("rst.out", ULA_OUT, 0);
        chk("rst.hi", ULA_OUT_HI, 0);
        chk("rst.flags", ULA_flags, 0);
        chk("rst.busy", ULA_busy, 0);
        chk("rst.done", ULA_done, 0);
        rst = 1'b0;
        tick();

        sc_op("add_ovf",  5'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001);
        sc_op("add_cy",   5'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110);
        sc_op("sub_zero", 5'h01, 32'd5, 32'd5, 32'h00000000, 4'b0100);
        sc_op("sub_brw",  5'h01, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b1010);
        sc_op("and",      5'h02, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000);
        sc_op("nand",     5'h03, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100);
        sc_op("or",       5'h04, 32'h0000000F, 32'hF0000000, 32'hF000000F, 4'b1000);
        sc_op("xor",      5'h05, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 4'b0100);
        sc_op("shr",      5'h06, 32'h00000003, 32'd1, 32'h00000001, 4'b0010);
        sc_op("sar",      5'h07, 32'h80000000, 32'd4, 32'hF8000000, 4'b1000);
        sc_op("shl_mod",  5'h08, 32'h00000001, 32'd32, 32'h00000001, 4'b0000);
        sc_op("shl_cy",   5'h08, 32'h80000001, 32'd1, 32'h00000002, 4'b0010);
        sc_op("rotl1",    5'h09, 32'h80000001, 32'd1, 32'h00000003, 4'b0010);
        sc_op("rotl0",    5'h09, 32'h80000001, 32'd0, 32'h80000001, 4'b1000);
        sc_op("rotr1",    5'h0A, 32'h00000001, 32'd1, 32'h80000000, 4'b1010);
        sc_op("not",      5'h0B, 32'h00000000, 32'd7, 32'hFFFFFFFF, 4'b1000);
        sc_op("illegal",  5'h0C, 32'd5, 32'd6, 32'h00000000, 4'b0100);

        mc_op("mulu",     5'h10, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'h00000001, 4'b1001, 5);
        mc_op("mulu_z",   5'h10, 32'd0, 32'd5, 32'h00000000, 32'h00000000, 4'b0100, -1);
        mc_op("divu",     5'h11, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000, -1);
        mc_op("divu_z",   5'h11, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 4'b1010, -1);
`ifdef ULA_SIGNED_MULDIV_EN
        mc_op("divs",     5'h13, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b1000, -1);
        mc_op("muls",     5'h12, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'hFFFFFFFF, 4'b1000, -1);
        mc_op("divs_min", 5'h13, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 4'b1001, -1);
`else
        mc_op("divs",     5'h13, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'h00000001, 4'b0000, -1);
        mc_op("muls",     5'h12, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'h00000004, 4'b1001, -1);
`endif

        // reset in the middle of a divide: abort without a done pulse
        ULA_ctrl  = 5'h11;
        ULA_A     = 32'd1000;
        ULA_B     = 32'd3;
        ULA_start = 1'b1;
        tick();
        ULA_start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("abort.busy_before", ULA_busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.busy", ULA_busy, 0);
        chk("abort.done", ULA_done, 0);
        chk("abort.out", ULA_OUT, 0);
        chk("abort.hi", ULA_OUT_HI, 0);
        chk("abort.flags", ULA_flags, 0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ULA_done) dones++;
        end
        chk("abort.no_done", dones, 0);
        sc_op("add_after", 5'h00, 32'd1, 32'd1, 32'd2, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
